uart_tx_arbiter: RTL and testbench

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_tx_arbiter.sv | 138 +++++++++++++
 tb/tb_uart_tx_arbiter.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that funnels single bytes from N_REQ requesters into one TX FIFO.
// Optional macro UART_ARB_PACKET_LOCK_EN holds a grant until the byte flagged req_last is accepted.
module uart_tx_arbiter #(
    parameter int N_REQ    = 4,
    parameter int ID_WIDTH = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic [N_REQ-1:0]      req_valid,
    input  logic [8*N_REQ-1:0]    req_data,
    input  logic [N_REQ-1:0]      req_last,
    output logic [N_REQ-1:0]      req_ready,
    input  logic                  tx_full,
    output logic                  tx_push,
    output logic [7:0]            tx_data,
    output logic [ID_WIDTH-1:0]   grant_id,
    output logic                  busy
);

    typedef enum logic {IDLE, XFER} state_t;

    state_t              state, state_nxt;
    logic [ID_WIDTH-1:0] rr_ptr, rr_ptr_nxt, grant_nxt;
    logic [ID_WIDTH-1:0] pick;
    logic                sel_valid;
    logic [7:0]          sel_data;
    logic                accept;
    logic                xfer_open;
    logic                grant_done;

    function automatic logic [ID_WIDTH-1:0] wrap_inc(input logic [ID_WIDTH-1:0] id);
        if (id >= ID_WIDTH'(N_REQ - 1))
            return '0;
        else
            return id + ID_WIDTH'(1);
    endfunction

    // First asserted requester at or after ptr, scanning by distance so the wrap is implicit.
    function automatic logic [ID_WIDTH-1:0] rr_select(input logic [N_REQ-1:0] v,
                                                      input logic [ID_WIDTH-1:0] ptr);
        logic [ID_WIDTH-1:0] sel;
        logic                found;
        sel   = '0;
        found = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            for (int i = 0; i < N_REQ; i++) begin
                if (!found && v[i] && (i == (int'(ptr) + k) % N_REQ)) begin
                    found = 1'b1;
                    sel   = ID_WIDTH'(i);
                end
            end
        end
        return sel;
    endfunction

`ifdef UART_ARB_PACKET_LOCK_EN
    logic sel_last;
`else
    logic last_unused;
    assign last_unused = ^req_last;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            grant_id <= '0;
        end else begin
            state    <= state_nxt;
            rr_ptr   <= rr_ptr_nxt;
            grant_id <= grant_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        rr_ptr_nxt = rr_ptr;
        grant_nxt  = grant_id;
        sel_valid  = 1'b0;
        sel_data   = 8'h00;
`ifdef UART_ARB_PACKET_LOCK_EN
        sel_last   = 1'b0;
`endif
        req_ready  = '0;
        grant_done = 1'b0;
        pick       = rr_select(req_valid, rr_ptr);

        for (int i = 0; i < N_REQ; i++) begin
            if (grant_id == ID_WIDTH'(i)) begin
                sel_valid = req_valid[i];
                sel_data  = req_data[8*i +: 8];
`ifdef UART_ARB_PACKET_LOCK_EN
                sel_last  = req_last[i];
`endif
            end
        end

        // clear suppresses the handshake in the same cycle it flushes the grant.
        xfer_open = (state == XFER) && !clear;
        for (int i = 0; i < N_REQ; i++) begin
            req_ready[i] = xfer_open && !tx_full && (grant_id == ID_WIDTH'(i));
        end
        accept  = xfer_open && !tx_full && sel_valid;
        tx_push = accept;
        tx_data = (state == XFER) ? sel_data : 8'h00;
        busy    = (state == XFER);

`ifdef UART_ARB_PACKET_LOCK_EN
        grant_done = accept && sel_last;
`else
        grant_done = accept || !sel_valid;
`endif

        if (clear) begin
            state_nxt  = IDLE;
            rr_ptr_nxt = '0;
            grant_nxt  = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req_valid) begin
                        grant_nxt = pick;
                        state_nxt = XFER;
                    end
                end
                XFER: begin
                    if (grant_done) begin
                        state_nxt  = IDLE;
                        rr_ptr_nxt = wrap_inc(grant_id);
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter; observes {busy, tx_push, grant_id, req_ready, tx_data} each cycle.
module tb_uart_tx_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        clear;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_last;
    logic [3:0]  req_ready;
    logic        tx_full;
    logic        tx_push;
    logic [7:0]  tx_data;
    logic [1:0]  grant_id;
    logic        busy;
    logic [15:0] obs;

    int total = 0;
    int bad   = 0;

    uart_tx_arbiter #(.N_REQ(4), .ID_WIDTH(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .clear     (clear),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .tx_full   (tx_full),
        .tx_push   (tx_push),
        .tx_data   (tx_data),
        .grant_id  (grant_id),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    assign obs = {busy, tx_push, grant_id, req_ready, tx_data};

    task automatic apply_reset();
        reset     = 1'b1;
        clear     = 1'b0;
        req_valid = '0;
        req_last  = '1;
        tx_full   = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        logic [15:0] exp;
        reset     = 1'b1;
        clear     = 1'b0;
        req_valid = 4'hF;
        req_data  = 32'h44332211;
        req_last  = '1;
        tx_full   = 1'b0;
        exp       = 16'h0000;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            #1;
            total++;
            if (obs !== exp) begin
                bad++;
                $display("FAIL reset_hold c=%0d: got %h want %h", c, obs, exp);
            end
        end
        @(negedge clk);
        req_valid = '0;
        reset     = 1'b0;
        #1;
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL reset_release: got %h want %h", obs, exp);
        end
    endtask

    task automatic test_round_robin();
        logic [15:0] exp;
        int g;
        apply_reset();
        @(negedge clk);
        req_valid = 4'hF;
        req_data  = 32'h44332211;
        tx_full   = 1'b0;
        for (int c = 0; c < 10; c++) begin
            #1;
            if (c % 2 == 1) begin
                g   = (c / 2) % 4;
                exp = {1'b1, 1'b1, 2'(g), 4'(1 << g), 8'(8'h11 * (g + 1))};
            end else begin
                g   = (c == 0) ? 0 : ((c - 1) / 2) % 4;
                exp = {1'b0, 1'b0, 2'(g), 4'b0000, 8'h00};
            end
            total++;
            if (obs !== exp) begin
                bad++;
                $display("FAIL round_robin c=%0d: got %h want %h", c, obs, exp);
            end
            @(negedge clk);
        end
        req_valid = '0;
    endtask

    task automatic test_full();
        logic [15:0] exp;
        apply_reset();
        @(negedge clk);
        req_valid = 4'b0100;
        req_data  = 32'h005A0000;
        tx_full   = 1'b1;
        for (int c = 0; c < 7; c++) begin
            if (c == 5) tx_full = 1'b0;
            if (c == 6) req_valid = '0;
            #1;
            if (c == 0)      exp = 16'h0000;
            else if (c < 5)  exp = {1'b1, 1'b0, 2'd2, 4'b0000, 8'h5A};
            else if (c == 5) exp = {1'b1, 1'b1, 2'd2, 4'b0100, 8'h5A};
            else             exp = {1'b0, 1'b0, 2'd2, 4'b0000, 8'h00};
            total++;
            if (obs !== exp) begin
                bad++;
                $display("FAIL full_stall c=%0d: got %h want %h", c, obs, exp);
            end
            @(negedge clk);
        end
    endtask

`ifndef UART_ARB_PACKET_LOCK_EN
    task automatic test_drop();
        logic [15:0] exp [5];
        exp[0] = 16'h0000;
        exp[1] = {1'b1, 1'b0, 2'd1, 4'b0010, 8'h22};
        exp[2] = {1'b0, 1'b0, 2'd1, 4'b0000, 8'h00};
        exp[3] = {1'b1, 1'b1, 2'd0, 4'b0001, 8'h11};
        exp[4] = {1'b0, 1'b0, 2'd0, 4'b0000, 8'h00};
        apply_reset();
        @(negedge clk);
        req_valid = 4'b0010;
        req_data  = 32'h44332211;
        req_last  = 4'b0000;
        for (int c = 0; c < 5; c++) begin
            if (c == 1) req_valid = 4'b0000;
            if (c == 2) req_valid = 4'b0011;
            if (c == 4) req_valid = 4'b0000;
            #1;
            total++;
            if (obs !== exp[c]) begin
                bad++;
                $display("FAIL valid_drop c=%0d: got %h want %h", c, obs, exp[c]);
            end
            @(negedge clk);
        end
        req_last = '1;
    endtask
`endif

    task automatic test_clear();
        logic [15:0] exp [6];
        exp[0] = 16'h0000;
        exp[1] = {1'b1, 1'b1, 2'd0, 4'b0001, 8'h11};
        exp[2] = {1'b0, 1'b0, 2'd0, 4'b0000, 8'h00};
        exp[3] = {1'b1, 1'b0, 2'd1, 4'b0000, 8'h22};
        exp[4] = {1'b0, 1'b0, 2'd0, 4'b0000, 8'h00};
        exp[5] = {1'b1, 1'b1, 2'd0, 4'b0001, 8'h11};
        apply_reset();
        @(negedge clk);
        req_valid = 4'hF;
        req_data  = 32'h44332211;
        for (int c = 0; c < 6; c++) begin
            clear = (c == 3);
            #1;
            total++;
            if (obs !== exp[c]) begin
                bad++;
                $display("FAIL clear_flush c=%0d: got %h want %h", c, obs, exp[c]);
            end
            @(negedge clk);
        end
        clear     = 1'b0;
        req_valid = '0;
    endtask

    task automatic test_reset_mid();
        logic [15:0] exp [6];
        exp[0] = 16'h0000;
        exp[1] = {1'b1, 1'b0, 2'd3, 4'b0000, 8'h44};
        exp[2] = 16'h0000;
        exp[3] = 16'h0000;
        exp[4] = 16'h0000;
        exp[5] = {1'b1, 1'b1, 2'd3, 4'b1000, 8'h44};
        apply_reset();
        @(negedge clk);
        req_valid = 4'b1000;
        req_data  = 32'h44332211;
        tx_full   = 1'b1;
        for (int c = 0; c < 6; c++) begin
            if (c == 2) begin
                reset   = 1'b1;
                tx_full = 1'b0;
            end
            if (c == 4) reset = 1'b0;
            #1;
            total++;
            if (obs !== exp[c]) begin
                bad++;
                $display("FAIL reset_mid c=%0d: got %h want %h", c, obs, exp[c]);
            end
            @(negedge clk);
        end
        req_valid = '0;
    endtask

`ifdef UART_ARB_PACKET_LOCK_EN
    task automatic test_packet_lock();
        logic [15:0] exp [6];
        exp[0] = 16'h0000;
        exp[1] = {1'b1, 1'b1, 2'd1, 4'b0010, 8'h11};
        exp[2] = {1'b1, 1'b1, 2'd1, 4'b0010, 8'h22};
        exp[3] = {1'b1, 1'b1, 2'd1, 4'b0010, 8'h33};
        exp[4] = {1'b0, 1'b0, 2'd1, 4'b0000, 8'h00};
        exp[5] = {1'b1, 1'b1, 2'd0, 4'b0001, 8'hA0};
        apply_reset();
        @(negedge clk);
        req_valid = 4'b0010;
        req_data  = 32'h000011A0;
        req_last  = 4'b0000;
        for (int c = 0; c < 6; c++) begin
            if (c == 1) begin
                req_valid = 4'b0011;
                req_last  = 4'b0001;
            end
            if (c == 2) req_data[15:8] = 8'h22;
            if (c == 3) begin
                req_data[15:8] = 8'h33;
                req_last       = 4'b0011;
            end
            if (c == 4) req_valid = 4'b0001;
            #1;
            total++;
            if (obs !== exp[c]) begin
                bad++;
                $display("FAIL packet_lock c=%0d: got %h want %h", c, obs, exp[c]);
            end
            @(negedge clk);
        end
        req_valid = '0;
    endtask

    task automatic test_lock_hold();
        logic [15:0] exp [6];
        exp[0] = 16'h0000;
        exp[1] = {1'b1, 1'b1, 2'd1, 4'b0010, 8'h11};
        exp[2] = {1'b1, 1'b0, 2'd1, 4'b0010, 8'h11};
        exp[3] = {1'b1, 1'b0, 2'd1, 4'b0010, 8'h11};
        exp[4] = {1'b1, 1'b0, 2'd1, 4'b0000, 8'h11};
        exp[5] = 16'h0000;
        apply_reset();
        @(negedge clk);
        req_valid = 4'b0010;
        req_data  = 32'h000011A0;
        req_last  = 4'b0000;
        for (int c = 0; c < 6; c++) begin
            if (c == 2) req_valid = 4'b0001;
            clear = (c == 4);
            #1;
            total++;
            if (obs !== exp[c]) begin
                bad++;
                $display("FAIL lock_hold c=%0d: got %h want %h", c, obs, exp[c]);
            end
            @(negedge clk);
        end
        clear     = 1'b0;
        req_valid = '0;
        req_last  = '1;
    endtask
`endif

    initial begin
        reset     = 1'b1;
        clear     = 1'b0;
        req_valid = '0;
        req_data  = '0;
        req_last  = '1;
        tx_full   = 1'b0;
        test_reset();
        test_round_robin();
        test_full();
`ifndef UART_ARB_PACKET_LOCK_EN
        test_drop();
`endif
        test_clear();
        test_reset_mid();
`ifdef UART_ARB_PACKET_LOCK_EN
        test_packet_lock();
        test_lock_hold();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded 100000 time units");
        $fatal(1);
    end

endmodule
